// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared encodings for the data-memory port arbiter
package dmem_arbiter_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arbState_t;

  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DMA = 1'b1;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/dmem_rd_tracker.sv
// rtl/dmem_rd_tracker.sv - remembers which requester owns the read in flight
// and decodes the per-owner rvalid one cycle after the grant.
module dmem_rd_tracker
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic isRead,
  input  logic owner,
  output logic cpu_rvalid,
  output logic dma_rvalid
);

  logic rdPend;
  logic rdOwner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPend  <= 1'b0;
      rdOwner <= OWN_CPU;
    end else begin
      rdPend <= issue & isRead;
      if (issue & isRead) rdOwner <= owner;
    end
  end

  assign cpu_rvalid = rdPend & (rdOwner == OWN_CPU);
  assign dma_rvalid = rdPend & (rdOwner == OWN_DMA);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares DMEM block-RAM port A between the CPU X-stage
// and a DMA requester; CPU-first with starvation force-grant and bounded DMA bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int BURST_W  = $clog2(BURST_MAX + 1);

  arbState_t           state;
  arbState_t           nextState;
  logic [STARVE_W-1:0] starveCnt;
  logic [BURST_W-1:0]  burstCnt;
  logic                starved;
  logic                burstLast;

  assign starved   = dma_req && (starveCnt == STARVE_W'(STARVE_MAX));
  assign burstLast = (burstCnt == BURST_W'(BURST_MAX - 1));

  always_comb begin
    nextState = state;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    case (state)
      S_CPU: begin
        if (starved)      dma_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
        else if (dma_req) dma_gnt = 1'b1;
        if (dma_gnt && dma_lock) nextState = S_DMA;
      end
      S_DMA: begin
        dma_gnt = dma_req;
        if (!dma_lock || !dma_req || burstLast) nextState = S_CPU;
      end
      default: nextState = S_CPU;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CPU;
    else     state <= nextState;
  end

  // The beat that takes the lock in S_CPU counts as the first beat of the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burstCnt <= '0;
    end else if (nextState == S_CPU) begin
      burstCnt <= '0;
    end else if (state == S_CPU) begin
      burstCnt <= BURST_W'(1);
    end else if (dma_gnt) begin
      burstCnt <= burstCnt + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (dma_gnt || !dma_req) begin
      starveCnt <= '0;
    end else if (starveCnt != STARVE_W'(STARVE_MAX)) begin
      starveCnt <= starveCnt + STARVE_W'(1);
    end
  end

  // Idle cycles leave the CPU address/data on the port so only mem_en/mem_we toggle.
  assign mem_en   = cpu_gnt | dma_gnt;
  assign mem_we   = dma_gnt ? dma_we    : (cpu_gnt ? cpu_we : WE_NONE);
  assign mem_addr = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_din  = dma_gnt ? dma_wdata : cpu_wdata;
  assign rdata    = mem_dout;

  dmem_rd_tracker u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .issue      (mem_en),
    .isRead     (mem_we == WE_NONE),
    .owner      (dma_gnt ? OWN_DMA : OWN_CPU),
    .cpu_rvalid (cpu_rvalid),
    .dma_rvalid (dma_rvalid)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic        dma_req, dma_lock;
  logic [3:0]  dma_we;
  logic [11:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:4095];

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Read-first block-RAM model with byte enables.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_lock = 1'b0; dma_we = 4'h0; dma_addr = '0; dma_wdata = '0;
  endtask

  initial begin
    mem[1] <= 32'hDEADBEEF;
    mem[2] <= 32'h12345678;
    rst = 1'b1;
    idleInputs();

    // Reset state
    #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_state", 32'(dut.state), 32'(S_CPU));
    chk("rst_starve", 32'(dut.starveCnt), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // CPU-only reads of words 1 and 2
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 12'd1; #1;
    chk("rd0_cpu_gnt", 32'(cpu_gnt), 1);
    chk("rd0_cpu_stall", 32'(cpu_stall), 0);
    chk("rd0_mem_addr", 32'(mem_addr), 1);
    @(negedge clk);
    cpu_addr = 12'd2; #1;
    chk("rd1_cpu_gnt", 32'(cpu_gnt), 1);
    chk("rd1_cpu_stall", 32'(cpu_stall), 0);
    chk("rd0_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("rd0_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    cpu_req = 1'b0; #1;
    chk("rd1_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("rd1_rdata", rdata, 32'h12345678);
    chk("rd1_dma_rvalid", 32'(dma_rvalid), 0);
    @(negedge clk); #1;
    chk("rd_done_rvalid", 32'(cpu_rvalid), 0);

    // Reset pulsed while a CPU read response is pending
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 12'd1; #1;
    chk("rstmid_gnt", 32'(cpu_gnt), 1);
    @(posedge clk); #2;
    cpu_req = 1'b0;
    chk("rstmid_pre_rvalid", 32'(cpu_rvalid), 1);
    rst = 1'b1; #1;
    chk("rstmid_rvalid", 32'(cpu_rvalid), 0);
    chk("rstmid_state", 32'(dut.state), 32'(S_CPU));
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_after0", 32'(cpu_rvalid), 0);
    @(negedge clk); #1;
    chk("rstmid_after1", 32'(cpu_rvalid), 0);

    // Starvation: CPU and DMA both held, DMA wins after 8 refusals
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 12'd1;
      dma_req = 1'b1; dma_lock = 1'b0; dma_we = 4'h0; dma_addr = 12'd2; #1;
      chk($sformatf("starve_cpu_gnt%0d", i), 32'(cpu_gnt), 1);
      chk($sformatf("starve_dma_gnt%0d", i), 32'(dma_gnt), 0);
    end
    @(negedge clk); #1;
    chk("starve_force_dma_gnt", 32'(dma_gnt), 1);
    chk("starve_force_cpu_gnt", 32'(cpu_gnt), 0);
    chk("starve_force_stall", 32'(cpu_stall), 1);
    chk("starve_force_addr", 32'(mem_addr), 2);
    @(negedge clk); #1;
    chk("starve_cnt_clear", 32'(dut.starveCnt), 0);
    chk("starve_cpu_back", 32'(cpu_gnt), 1);
    chk("starve_dma_rvalid", 32'(dma_rvalid), 1);
    chk("starve_dma_rdata", rdata, 32'h12345678);
    @(negedge clk);
    idleInputs();
    @(negedge clk);

    // Locked DMA write burst of 20 requested beats, CPU joins at beat 3
    for (int b = 1; b <= 20; b++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_lock = 1'b1; dma_we = 4'hF;
      dma_addr = 12'(12'h100 + b); dma_wdata = 32'(b);
      cpu_req = (b >= 3); cpu_we = 4'h0; cpu_addr = 12'd1; #1;
      chk($sformatf("burst_dma_gnt%0d", b), 32'(dma_gnt), (b <= 16) ? 1 : 0);
      chk($sformatf("burst_cpu_gnt%0d", b), 32'(cpu_gnt), (b >= 17) ? 1 : 0);
      chk($sformatf("burst_stall%0d", b), 32'(cpu_stall), (b >= 3 && b <= 16) ? 1 : 0);
      chk($sformatf("burst_dma_rvalid%0d", b), 32'(dma_rvalid), 0);
    end
    @(negedge clk);
    idleInputs();
    @(negedge clk); @(negedge clk);
    chk("burst_mem_beat16", mem[12'h110], 32'd16);

    // CPU write then DMA read of the same word
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idleInputs();
      cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 12'd4;
      cpu_wdata = (k == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A; #1;
      chk($sformatf("alt_cpu_gnt%0d", k), 32'(cpu_gnt), 1);
      chk($sformatf("alt_mem_we%0d", k), 32'(mem_we), 32'hF);
      @(negedge clk);
      idleInputs();
      dma_req = 1'b1; dma_addr = 12'd4; #1;
      chk($sformatf("alt_dma_gnt%0d", k), 32'(dma_gnt), 1);
      chk($sformatf("alt_wr_cpu_rvalid%0d", k), 32'(cpu_rvalid), 0);
      @(negedge clk);
      idleInputs(); #1;
      chk($sformatf("alt_dma_rvalid%0d", k), 32'(dma_rvalid), 1);
      chk($sformatf("alt_rdata%0d", k), rdata, (k == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
      chk($sformatf("alt_cpu_rvalid%0d", k), 32'(cpu_rvalid), 0);
    end

    // Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idleInputs();
      cpu_addr = 12'd7; #1;
      chk($sformatf("idle_mem_en%0d", i), 32'(mem_en), 0);
      chk($sformatf("idle_mem_we%0d", i), 32'(mem_we), 0);
      chk($sformatf("idle_mem_addr%0d", i), 32'(mem_addr), 7);
      chk($sformatf("idle_gnt%0d", i), 32'({cpu_gnt, dma_gnt}), 0);
      chk($sformatf("idle_rvalid%0d", i), 32'({cpu_rvalid, dma_rvalid}), 0);
      chk($sformatf("idle_starve%0d", i), 32'(dut.starveCnt), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
